// File: rtl/fifo_serial_tx_pkg.sv
// fifo_serial_tx_pkg: shared types and constants for the FIFO-draining serial transmitter.
//   tx_state_e  : frame sequencer states
//   BYTE_W      : width of one FIFO entry / one frame payload
//   IDLE_LEVEL  : line level while idle and during the stop bit
//   START_LEVEL : line level of the start bit
package fifo_serial_tx_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: baud counter for one serial bit period.
//   clk          : clock
//   reset        : synchronous active-high reset
//   clear        : hold the counter at 0 (asserted while not in a timed state)
//   bit_end      : high in the last cycle of a bit period (terminal count)
//   bit_end_next : high in the cycle before the terminal count
// The counter wraps to 0 on its own at terminal count, so a timed state entered
// on that edge always starts from 0.
module tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic bit_end_next
);

    localparam int unsigned    CntW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntPenult = CntW'(CLKS_PER_BIT - 2);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end      = (cnt_q == CntLast);
    // Lets the owner register a pulse that lands exactly on the terminal-count cycle.
    assign bit_end_next = !clear && (cnt_q == CntPenult);

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops bytes from a FIFO and sends each as a serial frame:
// start bit, 8 data bits LSB first, optional even-parity bit, stop bit.
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty : FIFO empty flag, only looked at while idle
//   fifo_rd_en : one-cycle pop request
//   tx         : serial line, idles high
//   busy       : high from the pop through the end of the stop bit
//   frame_done : one-cycle pulse in the last cycle of the stop bit
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    tx_state_e         state_q;
    logic [BYTE_W-1:0] shreg_q;
    logic              parity_q;
    logic [2:0]        bit_idx_q;
    logic              tx_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              frame_done_q;

    logic timer_clear;
    logic bit_end;
    logic bit_end_next;

    // Only the line-timed states run the baud counter.
    assign timer_clear = (state_q == StIdle) || (state_q == StFetch) || (state_q == StLoad);

    tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (timer_clear),
        .bit_end      (bit_end),
        .bit_end_next (bit_end_next)
    );

    // tx is updated on the edge that enters each state, so the line always
    // shows the level belonging to the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            parity_q     <= 1'b0;
            bit_idx_q    <= '0;
            tx_q         <= IDLE_LEVEL;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tx_q <= IDLE_LEVEL;
                    if (!fifo_empty) begin
                        state_q <= StFetch;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    shreg_q  <= fifo_data;
                    parity_q <= even_parity(fifo_data);
                    state_q  <= StStart;
                    tx_q     <= START_LEVEL;
                end
                StStart: begin
                    if (bit_end) begin
                        state_q   <= StData;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shreg_q   <= shreg_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY_EN) begin
                                state_q <= StParity;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= StStop;
                                tx_q    <= IDLE_LEVEL;
                            end
                        end else begin
                            // Next bit is what sits in shreg[1] before the shift lands.
                            tx_q <= shreg_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        tx_q    <= IDLE_LEVEL;
                    end
                end
                StStop: begin
                    frame_done_q <= bit_end_next;
                    if (bit_end) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        tx_q    <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    tx_q    <= IDLE_LEVEL;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
